ee357_mcpu_fetch: RTL and testbench

EE357_MCPU_FETCH -- requirements
Module: ee357_mcpu_fetch

---
 rtl/ee357_mcpu_fetch_if.sv | 38 +++
 rtl/ee357_mcpu_fetch.sv | 78 +++++++
 tb/tb_ee357_mcpu_fetch.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ee357_mcpu_fetch_if.sv
// Signal bundle between the multicycle control/datapath and the fetch block.
// The master drives control and datapath results; the slave returns registers, address and decode.
interface ee357_mcpu_fetch_if;
    logic        pcw;
    logic        pcwc;
    logic        iord;
    logic        mr;
    logic        irw;
    logic        tw;
    logic [1:0]  pcs;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sx;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] aluout_q;
    logic [31:0] target;
    logic [31:0] instr_cnt;

    modport master (
        output pcw, pcwc, iord, mr, irw, tw, pcs, alu_out, alu_zero, mem_rdata,
        input  mem_addr, op, func, rs, rt, rd, imm_sx, pc, ir, mdr, aluout_q, target, instr_cnt
    );

    modport slave (
        input  pcw, pcwc, iord, mr, irw, tw, pcs, alu_out, alu_zero, mem_rdata,
        output mem_addr, op, func, rs, rt, rd, imm_sx, pc, ir, mdr, aluout_q, target, instr_cnt
    );
endinterface

// File: rtl/ee357_mcpu_fetch.sv
// Multicycle CPU fetch/PC unit: PC, IR, MDR, ALUOut and branch Target registers,
// memory address mux, next-PC selection and instruction decode fields.
module ee357_mcpu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  OP_BNE   = 6'b000101
) (
    input logic             clk,
    input logic             rst,
    ee357_mcpu_fetch_if.slave bus
);

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] mdr_q;
    logic [31:0] aluout_q;
    logic [31:0] target_q;
    logic [31:0] instr_cnt_q;

    logic        is_bne;
    logic        br_taken;
    logic        pc_load;
    logic [31:0] next_pc;

    // BNE flips the sense of the zero test; pcs=11 is reserved and never loads the PC.
    always_comb begin
        is_bne   = (ir_q[31:26] == OP_BNE);
        br_taken = bus.pcwc & (bus.alu_zero ^ is_bne);
        pc_load  = (bus.pcw | br_taken) & (bus.pcs != 2'b11);
        next_pc  = pc_q;
        case (bus.pcs)
            2'b00:   next_pc = bus.alu_out;
            2'b01:   next_pc = target_q;
            2'b10:   next_pc = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: next_pc = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            mdr_q       <= '0;
            aluout_q    <= '0;
            target_q    <= '0;
            instr_cnt_q <= '0;
        end else begin
            aluout_q <= bus.alu_out;
            if (bus.irw) begin
                ir_q        <= bus.mem_rdata;
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
            if (bus.mr && bus.iord) begin
                mdr_q <= bus.mem_rdata;
            end
            if (bus.tw) begin
                target_q <= bus.alu_out;
            end
            if (pc_load) begin
                pc_q <= next_pc;
            end
        end
    end

    assign bus.mem_addr  = bus.iord ? aluout_q : pc_q;
    assign bus.op        = ir_q[31:26];
    assign bus.func      = ir_q[5:0];
    assign bus.rs        = ir_q[25:21];
    assign bus.rt        = ir_q[20:16];
    assign bus.rd        = ir_q[15:11];
    assign bus.imm_sx    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.mdr       = mdr_q;
    assign bus.aluout_q  = aluout_q;
    assign bus.target    = target_q;
    assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_ee357_mcpu_fetch.sv
// Directed bench for ee357_mcpu_fetch: a register-level reference model checked every cycle,
// plus literal expectations at each scenario that pin the model.
module tb_ee357_mcpu_fetch;
    logic clk;
    logic rst;
    ee357_mcpu_fetch_if bus();

    ee357_mcpu_fetch #(.RESET_PC(32'h0000_0000), .OP_BNE(6'b000101)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    // Reference state: what each architectural register must hold after the last edge.
    logic [31:0] m_pc, m_ir, m_mdr, m_alq, m_tgt, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        logic [31:0] npc;
        logic        taken;
        if (rst) begin
            m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0;
            m_alq = 32'h0; m_tgt = 32'h0; m_cnt = 32'h0;
        end else begin
            taken = bus.pcwc && (bus.alu_zero != (m_ir[31:26] == 6'b000101));
            if (bus.pcs == 2'd0)      npc = bus.alu_out;
            else if (bus.pcs == 2'd1) npc = m_tgt;
            else                      npc = {m_pc[31:28], m_ir[25:0], 2'b00};
            if ((bus.pcw || taken) && bus.pcs != 2'd3) m_pc = npc;
            if (bus.irw) begin
                m_ir  = bus.mem_rdata;
                m_cnt = m_cnt + 1;
            end
            if (bus.mr && bus.iord) m_mdr = bus.mem_rdata;
            if (bus.tw) m_tgt = bus.alu_out;
            m_alq = bus.alu_out;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", bus.pc, m_pc);
            chk("ir", bus.ir, m_ir);
            chk("mdr", bus.mdr, m_mdr);
            chk("aluout_q", bus.aluout_q, m_alq);
            chk("target", bus.target, m_tgt);
            chk("instr_cnt", bus.instr_cnt, m_cnt);
            chk("mem_addr", bus.mem_addr, bus.iord ? m_alq : m_pc);
            chk("decode", {bus.op, bus.rs, bus.rt, bus.rd, bus.func},
                {m_ir[31:26], m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[5:0]});
            chk("imm_sx", bus.imm_sx, {{16{m_ir[15]}}, m_ir[15:0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic idle();
        bus.pcw = 0; bus.pcwc = 0; bus.iord = 0; bus.mr = 0;
        bus.irw = 0; bus.tw = 0; bus.pcs = 2'b00; bus.alu_zero = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.alu_out = 32'h0; bus.mem_rdata = 32'h0;

        // Reset state
        tick();
        cmp_en = 1'b1;
        chk("rst pc", bus.pc, 32'h0);
        chk("rst ir", bus.ir, 32'h0);
        chk("rst cnt", bus.instr_cnt, 32'h0);
        chk("rst op/func", {26'h0, bus.op}, {26'h0, bus.func});
        chk("rst op", {26'h0, bus.op}, 32'h0);

        // Fetch: IR gets word at old pc, pc gets alu_out
        rst = 1'b0;
        bus.mem_rdata = 32'h8C22_0004; bus.alu_out = 32'h4; bus.irw = 1; bus.pcw = 1;
        tick();
        chk("fetch ir", bus.ir, 32'h8C22_0004);
        chk("fetch op", {26'h0, bus.op}, 32'h23);
        chk("fetch pc", bus.pc, 32'h4);
        chk("fetch cnt", bus.instr_cnt, 32'h1);
        chk("fetch imm", bus.imm_sx, 32'h4);

        // Load path
        idle(); bus.tw = 1; bus.alu_out = 32'h18;
        tick();
        chk("target 18", bus.target, 32'h18);
        idle(); bus.alu_out = 32'h100;
        tick();
        bus.iord = 1; bus.mr = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        #1 chk("mem_addr alu", bus.mem_addr, 32'h100);
        tick();
        chk("mdr load", bus.mdr, 32'hDEAD_BEEF);
        bus.iord = 0; bus.mem_rdata = 32'h1111_1111;
        #1 chk("mem_addr pc", bus.mem_addr, 32'h4);
        tick();
        chk("mdr hold", bus.mdr, 32'hDEAD_BEEF);

        // BEQ
        idle(); bus.tw = 1; bus.alu_out = 32'h40;
        tick();
        idle(); bus.pcwc = 1; bus.pcs = 2'b01; bus.alu_zero = 0;
        tick();
        chk("beq not taken", bus.pc, 32'h4);
        bus.alu_zero = 1;
        tick();
        chk("beq taken", bus.pc, 32'h40);

        // BNE
        idle(); bus.irw = 1; bus.mem_rdata = 32'h1422_FFFC;
        tick();
        chk("bne imm_sx", bus.imm_sx, 32'hFFFF_FFFC);
        chk("bne cnt", bus.instr_cnt, 32'h2);
        idle(); bus.pcw = 1; bus.alu_out = 32'h8;
        tick();
        idle(); bus.pcwc = 1; bus.pcs = 2'b01; bus.alu_zero = 1;
        tick();
        chk("bne not taken", bus.pc, 32'h8);
        bus.alu_zero = 0;
        tick();
        chk("bne taken", bus.pc, 32'h40);

        // Jump
        idle(); bus.pcw = 1; bus.alu_out = 32'hA000_0008;
        tick();
        idle(); bus.irw = 1; bus.mem_rdata = 32'h0800_0010;
        tick();
        idle(); bus.pcw = 1; bus.pcs = 2'b10;
        tick();
        chk("jump pc", bus.pc, 32'hA000_0040);

        // Reserved encoding and pcw/pcwc conflict
        idle(); bus.pcw = 1; bus.pcwc = 1; bus.pcs = 2'b11; bus.alu_out = 32'h1234;
        tick();
        chk("pcs11 hold", bus.pc, 32'hA000_0040);
        idle(); bus.pcw = 1; bus.pcwc = 1; bus.alu_zero = 0; bus.alu_out = 32'h100;
        tick();
        chk("pcw dominates", bus.pc, 32'h100);

        // Asynchronous rst pulse between edges
        idle();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk("async rst pc", bus.pc, 32'h100);
        chk("async rst cnt", bus.instr_cnt, 32'h3);
        tick();
        chk("after pulse ir", bus.ir, 32'h0800_0010);

        // Reset dominates enables mid-instruction
        rst = 1'b1; bus.irw = 1; bus.tw = 1; bus.pcw = 1;
        bus.mem_rdata = 32'hFFFF_FFFF; bus.alu_out = 32'h55;
        tick();
        chk("mid rst pc", bus.pc, 32'h0);
        chk("mid rst ir", bus.ir, 32'h0);
        chk("mid rst target", bus.target, 32'h0);
        chk("mid rst aluout", bus.aluout_q, 32'h0);
        chk("mid rst mdr", bus.mdr, 32'h0);
        chk("mid rst cnt", bus.instr_cnt, 32'h0);
        rst = 1'b0; idle();
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
